// File: rtl/ppu_oam_dma.sv
// OAM DMA controller: copies NUM_BYTES bytes from {page,8'h00} on the system bus into OAM.
// Optional echo-RAM page folding is enabled by defining OAM_DMA_PAGE_FOLD_EN.
module ppu_oam_dma #(
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned STARTUP_CYCLES  = 4,
  parameter int unsigned NUM_BYTES       = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write,
  input  logic [7:0]  d_wr,
  output logic [7:0]  reg_d_rd,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  input  logic [7:0]  bus_d_rd,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_d_wr,
  output logic        oam_write,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam int unsigned SW  = $clog2(CYCLES_PER_BYTE);
  localparam int unsigned STW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [SW-1:0]  SLOT_LAST  = SW'(CYCLES_PER_BYTE - 1);
  localparam logic [STW-1:0] START_LAST = STW'(STARTUP_CYCLES - 1);
  localparam logic [7:0]     IDX_LAST   = 8'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_e;

  state_e         state_q;
  logic [7:0]     page_q;
  logic [STW-1:0] startup_ctr_q;
  logic [SW-1:0]  slot_ctr_q;
  logic [7:0]     idx_q;
  logic [7:0]     idx_d;
  logic [15:0]    bus_addr_q;
  logic           bus_rd_q;
  logic [7:0]     oam_addr_q;
  logic [7:0]     oam_d_wr_q;
  logic           oam_write_q;
  logic           busy_q;
  logic           done_q;
  logic [7:0]     src_page;

`ifdef OAM_DMA_PAGE_FOLD_EN
  // Echo RAM: pages E0..FF alias C0..DF.
  assign src_page = (page_q >= 8'hE0) ? page_q - 8'h20 : page_q;
`else
  assign src_page = page_q;
`endif

  assign idx_d = idx_q + 8'd1;

  // Strobes are registered one cycle ahead, so each is set on the edge that enters its slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      page_q        <= 8'hFF;
      startup_ctr_q <= '0;
      slot_ctr_q    <= '0;
      idx_q         <= '0;
      bus_addr_q    <= '0;
      bus_rd_q      <= 1'b0;
      oam_addr_q    <= '0;
      oam_d_wr_q    <= '0;
      oam_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      bus_rd_q    <= 1'b0;
      oam_write_q <= 1'b0;
      done_q      <= 1'b0;
      if (reg_write) begin
        state_q       <= START;
        page_q        <= d_wr;
        startup_ctr_q <= '0;
        slot_ctr_q    <= '0;
        idx_q         <= '0;
        busy_q        <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: ;
          START: begin
            if (startup_ctr_q == START_LAST) begin
              state_q    <= XFER;
              slot_ctr_q <= '0;
              idx_q      <= '0;
              bus_rd_q   <= 1'b1;
              bus_addr_q <= {src_page, 8'h00};
            end else begin
              startup_ctr_q <= startup_ctr_q + STW'(1);
            end
          end
          XFER: begin
            // oam_d_wr_q doubles as the data register captured in slot 1.
            if (slot_ctr_q == SW'(1)) begin
              oam_write_q <= 1'b1;
              oam_addr_q  <= idx_q;
              oam_d_wr_q  <= bus_d_rd;
            end
            if (slot_ctr_q == SLOT_LAST) begin
              slot_ctr_q <= '0;
              if (idx_q == IDX_LAST) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q      <= idx_d;
                bus_rd_q   <= 1'b1;
                bus_addr_q <= {src_page, idx_d};
              end
            end else begin
              slot_ctr_q <= slot_ctr_q + SW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign reg_d_rd  = page_q;
  assign bus_addr  = bus_addr_q;
  assign bus_rd    = bus_rd_q;
  assign oam_addr  = oam_addr_q;
  assign oam_d_wr  = oam_d_wr_q;
  assign oam_write = oam_write_q;
  assign dma_busy  = busy_q;
  assign dma_done  = done_q;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Scoreboard bench for ppu_oam_dma: a timeline model predicts every bus read, OAM write,
// done pulse, busy level and page readback; a negedge monitor consumes the predictions.
module tb_ppu_oam_dma;

  localparam int unsigned CPB  = 4;
  localparam int unsigned SU   = 4;
  localparam int unsigned NB   = 160;
  localparam int unsigned SPAN = SU + NB * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [7:0]  d_wr;
  logic [7:0]  reg_d_rd;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic [7:0]  bus_d_rd = 8'h00;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_d_wr;
  logic        oam_write;
  logic        dma_busy;
  logic        dma_done;

  ppu_oam_dma #(
    .CYCLES_PER_BYTE(CPB),
    .STARTUP_CYCLES (SU),
    .NUM_BYTES      (NB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .reg_write(reg_write),
    .d_wr     (d_wr),
    .reg_d_rd (reg_d_rd),
    .bus_addr (bus_addr),
    .bus_rd   (bus_rd),
    .bus_d_rd (bus_d_rd),
    .oam_addr (oam_addr),
    .oam_d_wr (oam_d_wr),
    .oam_write(oam_write),
    .dma_busy (dma_busy),
    .dma_done (dma_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:65535];
  // Read data is valid only in the cycle after bus_rd; other cycles carry garbage.
  always @(posedge clk) bus_d_rd <= bus_rd ? mem[bus_addr] : 8'($urandom);

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t         rd_q[$];
  ev_t         wr_q[$];
  int unsigned done_q[$];
  int unsigned busy_lo = 0, busy_hi = 0, pg_t = 0;
  logic [7:0]  pg_old = 8'hFF, pg_new = 8'hFF;

  function automatic logic [7:0] exp_page(int unsigned c);
    return (c >= pg_t) ? pg_new : pg_old;
  endfunction

  function automatic logic [7:0] fold(logic [7:0] p);
`ifdef OAM_DMA_PAGE_FOLD_EN
    return (p >= 8'hE0) ? p - 8'h20 : p;
`else
    return p;
`endif
  endfunction

  // Drop every predicted event at or after edge t: it has not happened yet.
  function automatic void prune(int unsigned t);
    while (rd_q.size() > 0 && rd_q[$].cyc >= t) void'(rd_q.pop_back());
    while (wr_q.size() > 0 && wr_q[$].cyc >= t) void'(wr_q.pop_back());
    while (done_q.size() > 0 && done_q[$] >= t) void'(done_q.pop_back());
  endfunction

  function automatic void model_write(int unsigned t, logic [7:0] p);
    logic [7:0] src;
    src = fold(p);
    prune(t);
    pg_old = exp_page(t - 1);
    pg_new = p;
    pg_t   = t;
    if (t > busy_hi) busy_lo = t;
    busy_hi = t + SPAN;
    for (int unsigned k = 0; k < NB; k++) begin
      logic [15:0] a;
      a = {src, 8'(k)};
      rd_q.push_back('{t + SU + CPB * k, a, 8'h00});
      wr_q.push_back('{t + SU + CPB * k + 2, {8'h00, 8'(k)}, mem[a]});
    end
    done_q.push_back(t + SPAN);
  endfunction

  function automatic void model_reset(int unsigned r);
    prune(r);
    pg_old = exp_page(r - 1);
    pg_new = 8'hFF;
    pg_t   = r;
    if (busy_hi > r) busy_hi = r;
  endfunction

  bit mon_en = 1'b0;

  always @(negedge clk) begin : monitor
    int unsigned c;
    bit e;
    if (mon_en) begin
      c = cyc;
      check("busy", {31'b0, dma_busy}, {31'b0, (c >= busy_lo && c < busy_hi)});
      check("reg_d_rd", {24'b0, reg_d_rd}, {24'b0, exp_page(c)});
      e = rd_q.size() > 0 && rd_q[0].cyc == c;
      check("bus_rd", {31'b0, bus_rd}, {31'b0, e});
      if (e) begin
        check("bus_addr", {16'b0, bus_addr}, {16'b0, rd_q[0].addr});
        void'(rd_q.pop_front());
      end
      e = wr_q.size() > 0 && wr_q[0].cyc == c;
      check("oam_write", {31'b0, oam_write}, {31'b0, e});
      if (e) begin
        check("oam_addr", {24'b0, oam_addr}, {16'b0, wr_q[0].addr});
        check("oam_d_wr", {24'b0, oam_d_wr}, {24'b0, wr_q[0].data});
        void'(wr_q.pop_front());
      end
      e = done_q.size() > 0 && done_q[0] == c;
      check("dma_done", {31'b0, dma_done}, {31'b0, e});
      if (e) void'(done_q.pop_front());
    end
  end

  // Callers are always at a negedge; cyc then names the last edge taken.
  task automatic wait_to(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Issue a register write that the DUT samples on edge t.
  task automatic dma_write(input logic [7:0] p, input int unsigned t);
    wait_to(t - 1);
    reg_write = 1'b1;
    d_wr      = p;
    model_write(t, p);
    @(negedge clk);
    reg_write = 1'b0;
    d_wr      = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned t0, r;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b0; reg_write = 1'b0; d_wr = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, dma_busy}, 32'd0);
    check("rst_done", {31'b0, dma_done}, 32'd0);
    check("rst_bus_rd", {31'b0, bus_rd}, 32'd0);
    check("rst_oam_write", {31'b0, oam_write}, 32'd0);
    check("rst_bus_addr", {16'b0, bus_addr}, 32'd0);
    check("rst_oam_addr", {24'b0, oam_addr}, 32'd0);
    check("rst_oam_d_wr", {24'b0, oam_d_wr}, 32'd0);
    check("rst_reg_d_rd", {24'b0, reg_d_rd}, 32'hFF);
    rst = 1'b1;
    mon_en = 1'b1;

    // Basic copy from page C1.
    t0 = cyc + 1;
    dma_write(8'hC1, t0);
    wait_to(busy_hi + 3);

    // Restart from D0 at idx 50, slot 1.
    t0 = cyc + 1;
    dma_write(8'hC0, t0);
    dma_write(8'hD0, t0 + SU + CPB * 50 + 2);
    wait_to(busy_hi + 3);

    // Reset at idx 80, then a clean transfer from page 80.
    t0 = cyc + 1;
    dma_write(8'($urandom), t0);
    r = t0 + SU + CPB * 80 + 1;
    wait_to(r - 1);
    rst = 1'b0;
    model_reset(r);
    @(negedge clk);
    rst = 1'b1;
    check("abort_busy", {31'b0, dma_busy}, 32'd0);
    check("abort_bus_rd", {31'b0, bus_rd}, 32'd0);
    check("abort_oam_write", {31'b0, oam_write}, 32'd0);
    check("abort_reg_d_rd", {24'b0, reg_d_rd}, 32'hFF);
    dma_write(8'h80, cyc + 1);
    wait_to(busy_hi + 3);

    // Echo-page write; readback is always the raw value.
    dma_write(8'hE3, cyc + 1);
    check("fold_reg_d_rd", {24'b0, reg_d_rd}, 32'hE3);
    wait_to(busy_hi + 3);

    // Write landing on the final slot-end edge.
    t0 = cyc + 1;
    dma_write(8'hC5, t0);
    dma_write(8'hC6, t0 + SPAN);
    wait_to(busy_hi + 3);

    // Random pages, random restarts, back-to-back starts.
    repeat (5) begin
      t0 = cyc + 1 + $urandom_range(2, 0);
      dma_write(8'($urandom), t0);
      if ($urandom_range(1, 0) == 1)
        dma_write(8'($urandom), t0 + $urandom_range(SPAN, 1));
      wait_to(busy_hi + $urandom_range(3, 1));
    end
    wait_to(busy_hi + 4);

    check("rd_q_left", rd_q.size(), 32'd0);
    check("wr_q_left", wr_q.size(), 32'd0);
    check("done_q_left", done_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
